// File: rtl/lfsrcheck_pkg.sv
// Shared definitions for the LFSR equivalence checker: FSM state encoding
// and MISR constants.
package lfsrcheck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_INIT = 16'hFFFF;

endpackage

// File: rtl/lfsr_check_misr.sv
// 16-bit MISR over the Fibonacci bit stream. The top instantiates it only
// when LFSR_CHECK_SIGNATURE_EN is defined.
module lfsr_check_misr
  import lfsrcheck_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_clear,
  input  logic        i_step,
  input  logic        i_bit,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic b);
    return {sig[14:0], 1'b0} ^ ((sig[15] ^ b) ? SIG_POLY : 16'h0000);
  endfunction

  // Signature register: reset and run start both reload the seed; each accepted beat steps it.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and takes priority over every other update in the same cycle.
    if (RST || i_clear) begin
      r_sig <= SIG_INIT;
    end else if (i_step) begin
      r_sig <= misr_step(r_sig, i_bit);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/lfsr_equiv_checker.sv
// Compares Fibonacci and Galois LFSR output bits over a programmed run,
// counting mismatches and recording the first mismatching beat index.
// Optional MISR signature output: define LFSR_CHECK_SIGNATURE_EN.
module lfsr_equiv_checker
  import lfsrcheck_pkg::*;
#(
  parameter int CNT_W             = 16,
  parameter int ABORT_ON_MISMATCH = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start__ENA,
  input  logic [CNT_W-1:0] start_count,
  output logic             start__RDY,
  input  logic             sample__ENA,
  input  logic             sample_fib,
  input  logic             sample_gal,
  output logic             sample__RDY,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatchCount,
  output logic [CNT_W-1:0] firstMismatch
`ifdef LFSR_CHECK_SIGNATURE_EN
  ,
  output logic [15:0]      signature
`endif
);

  localparam logic [CNT_W-1:0] ONE      = 1;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_index;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [CNT_W-1:0] r_first;

  logic w_start_fire;
  logic w_sample_fire;
  logic w_mismatch;
  logic w_last;
  logic w_end_run;

  // Ready signals come from the state register only, never from an ENA.
  assign start__RDY  = (r_state != RUN);
  assign sample__RDY = (r_state == RUN);

  assign w_start_fire  = start__ENA && start__RDY;
  assign w_sample_fire = sample__ENA && sample__RDY;
  assign w_mismatch    = sample_fib ^ sample_gal;
  // count is nonzero whenever we are in RUN, so count-1 never wraps here.
  assign w_last        = (r_index == (r_count - ONE));
  assign w_end_run     = w_last || ((ABORT_ON_MISMATCH != 0) && w_mismatch);

  // Next-state decode for the IDLE/RUN/DONE run controller.
  always_comb begin
    // NOTE: the default assignment up front means every path drives
    // w_state_next, so no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start__ENA) begin
          w_state_next = (start_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample__ENA && w_end_run) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and result registers: start clears results, each accepted beat updates them.
  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so every register in this
    // block samples the pre-edge values of the others.
    if (RST) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_count   <= '0;
      r_mis_cnt <= '0;
      r_first   <= ALL_ONES;
    end else begin
      r_state <= w_state_next;
      if (w_start_fire) begin
        r_index   <= '0;
        r_count   <= start_count;
        r_mis_cnt <= '0;
        r_first   <= ALL_ONES;
      end else if (w_sample_fire) begin
        r_index <= r_index + ONE;
        if (w_mismatch) begin
          // A zero count means this is the first mismatch of the run.
          if (r_mis_cnt == '0) begin
            r_first <= r_index;
          end
          if (r_mis_cnt != ALL_ONES) begin
            r_mis_cnt <= r_mis_cnt + ONE;
          end
        end
      end
    end
  end

  assign done          = (r_state == DONE);
  assign pass          = done && (r_mis_cnt == '0);
  assign mismatchCount = r_mis_cnt;
  assign firstMismatch = r_first;

`ifdef LFSR_CHECK_SIGNATURE_EN
  lfsr_check_misr u_misr (
    .CLK     (CLK),
    .RST     (RST),
    .i_clear (w_start_fire),
    .i_step  (w_sample_fire),
    .i_bit   (sample_fib),
    .o_sig   (signature)
  );
`endif

endmodule

// File: tb/tb_lfsr_equiv_checker.sv
// Directed bench for lfsr_equiv_checker: one default instance and one with
// ABORT_ON_MISMATCH=1 sharing the same stimulus. Signature checks apply when
// LFSR_CHECK_SIGNATURE_EN is defined.
module tb_lfsr_equiv_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start__ENA = 1'b0;
  logic [15:0] start_count = '0;
  logic        sample__ENA = 1'b0;
  logic        sample_fib = 1'b0;
  logic        sample_gal = 1'b0;

  logic        start_rdy, sample_rdy, done, pass;
  logic [15:0] mis_cnt, first_mis;
  logic        start_rdy_a, sample_rdy_a, done_a, pass_a;
  logic [15:0] mis_cnt_a, first_mis_a;
`ifdef LFSR_CHECK_SIGNATURE_EN
  logic [15:0] sig, sig_a;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  lfsr_equiv_checker #(.CNT_W(16), .ABORT_ON_MISMATCH(0)) dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start_count(start_count), .start__RDY(start_rdy),
    .sample__ENA(sample__ENA), .sample_fib(sample_fib), .sample_gal(sample_gal),
    .sample__RDY(sample_rdy), .done(done), .pass(pass),
    .mismatchCount(mis_cnt), .firstMismatch(first_mis)
`ifdef LFSR_CHECK_SIGNATURE_EN
    , .signature(sig)
`endif
  );

  lfsr_equiv_checker #(.CNT_W(16), .ABORT_ON_MISMATCH(1)) dut_a (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start_count(start_count), .start__RDY(start_rdy_a),
    .sample__ENA(sample__ENA), .sample_fib(sample_fib), .sample_gal(sample_gal),
    .sample__RDY(sample_rdy_a), .done(done_a), .pass(pass_a),
    .mismatchCount(mis_cnt_a), .firstMismatch(first_mis_a)
`ifdef LFSR_CHECK_SIGNATURE_EN
    , .signature(sig_a)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cnt);
    start__ENA  = 1'b1;
    start_count = cnt;
    tick();
    start__ENA  = 1'b0;
  endtask

  task automatic beat(input logic f, input logic g);
    sample__ENA = 1'b1;
    sample_fib  = f;
    sample_gal  = g;
    tick();
    sample__ENA = 1'b0;
  endtask

`ifdef LFSR_CHECK_SIGNATURE_EN
  function automatic logic [15:0] model_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  logic [15:0] exp_sig;
`endif

  initial begin
    // Reset: two cycles
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst_start_rdy", start_rdy, 1);
    check("rst_sample_rdy", sample_rdy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mis_cnt", mis_cnt, 0);
    check("rst_first", first_mis, 16'hFFFF);
`ifdef LFSR_CHECK_SIGNATURE_EN
    check("rst_sig", sig, 16'hFFFF);
    exp_sig = 16'hFFFF;
`endif

    // Clean run of 8 matching beats, back to back
    do_start(16'd8);
    check("clean_sample_rdy", sample_rdy, 1);
    check("clean_start_rdy", start_rdy, 0);
    for (int i = 0; i < 8; i++) begin
      sample__ENA = 1'b1;
      sample_fib  = i[0];
      sample_gal  = i[0];
`ifdef LFSR_CHECK_SIGNATURE_EN
      exp_sig = model_step(exp_sig, i[0]);
`endif
      tick();
      if (i == 6) check("clean_done_early", done, 0);
    end
    sample__ENA = 1'b0;
    check("clean_done", done, 1);
    check("clean_pass", pass, 1);
    check("clean_mis_cnt", mis_cnt, 0);
    check("clean_sample_rdy_low", sample_rdy, 0);
`ifdef LFSR_CHECK_SIGNATURE_EN
    check("clean_sig", sig, exp_sig);
`endif
    beat(1'b1, 1'b0);  // ninth beat must be ignored
    check("clean_extra_mis", mis_cnt, 0);
    check("clean_extra_pass", pass, 1);

    // Two mismatches at indices 3 and 7 out of 10
    do_start(16'd10);
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, (i == 3 || i == 7) ? 1'b0 : 1'b1);
      if (i == 3) begin
        check("two_mid_mis", mis_cnt, 1);
        check("two_mid_first", first_mis, 3);
      end
    end
    check("two_done", done, 1);
    check("two_mis_cnt", mis_cnt, 2);
    check("two_first", first_mis, 3);
    check("two_pass", pass, 0);

    // Restart from DONE: results held until the start edge, cleared after it
    start__ENA  = 1'b1;
    start_count = 16'd10;
    #1;
    check("restart_hold_mis", mis_cnt, 2);
    check("restart_hold_done", done, 1);
    tick();
    start__ENA = 1'b0;
    check("restart_mis", mis_cnt, 0);
    check("restart_first", first_mis, 16'hFFFF);
    check("restart_done", done, 0);
    check("restart_sample_rdy", sample_rdy, 1);

    // Abort mode: mismatch at index 4 ends the abort instance's run
    for (int i = 0; i < 5; i++) beat(1'b0, (i == 4) ? 1'b1 : 1'b0);
    check("abort_done", done_a, 1);
    check("abort_first", first_mis_a, 4);
    check("abort_mis", mis_cnt_a, 1);
    check("abort_sample_rdy", sample_rdy_a, 0);
    check("noabort_done", done, 0);
    check("noabort_first", first_mis, 4);

    // Start while the default instance is in RUN is ignored; abort instance
    // (in DONE) takes it as a zero-length run.
    do_start(16'd0);
    check("run_start_ignored_rdy", sample_rdy, 1);
    check("run_start_ignored_done", done, 0);
    check("abort_zero_done", done_a, 1);
    check("abort_zero_pass", pass_a, 1);
    for (int i = 5; i < 10; i++) beat(1'b1, 1'b1);
    check("noabort_end_done", done, 1);
    check("noabort_end_mis", mis_cnt, 1);
    check("noabort_end_pass", pass, 0);
    check("abort_ignores_beats", mis_cnt_a, 0);

    // Zero-length run: straight to DONE with pass
    do_start(16'd0);
    check("zero_done", done, 1);
    check("zero_pass", pass, 1);
    check("zero_first", first_mis, 16'hFFFF);

    // Single beat, fib=gal=0
    do_start(16'd1);
    beat(1'b0, 1'b0);
    check("one_done", done, 1);
    check("one_pass", pass, 1);
`ifdef LFSR_CHECK_SIGNATURE_EN
    check("one_sig", sig, 16'hEFDF);
`endif

    // Reset mid-run after 3 beats, with a sample presented in the reset cycle
    do_start(16'd10);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("pre_rst_mis", mis_cnt, 1);
    RST         = 1'b1;
    sample__ENA = 1'b1;
    sample_fib  = 1'b1;
    sample_gal  = 1'b0;
    tick();
    RST         = 1'b0;
    sample__ENA = 1'b0;
    check("midrst_start_rdy", start_rdy, 1);
    check("midrst_sample_rdy", sample_rdy, 0);
    check("midrst_done", done, 0);
    check("midrst_mis", mis_cnt, 0);
    check("midrst_first", first_mis, 16'hFFFF);
`ifdef LFSR_CHECK_SIGNATURE_EN
    check("midrst_sig", sig, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
